png_filter_row: RTL
===================

Name: png_filter_row

Overview:
- Per-scanline PNG filter stage inside png_top, directly upstream of lz77_top.
- Takes RGBA pixels one row at a time and applies one of the five PNG filter types per byte lane.
- Emits a one-beat filter-type header, then the filtered pixels, and signals row completion.
- Keeps the previous row in an internal line buffer for the Up, Average and Paeth predictors.

Parameters:
- MAX_W, 512: maximum supported image width in pixels; sets line buffer depth.
- PXL_WD, 32 (`DATA_PXL_WD): pixel width, 4 byte lanes as {R,G,B,A}, R in [31:24].

Ports:
- clk  input  1  system clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- cfg_w_i  input  `SIZE_W_WD  image width in pixels, 1..MAX_W; stable during a frame.
- cfg_h_i  input  `SIZE_H_WD  image height in rows, >=1; stable during a frame.
- cfg_typ_i  input  3  filter type: 0 None, 1 Sub, 2 Up, 3 Average, 4 Paeth; values 5..7 treated as 0.
- start_i  input  1  one-cycle pulse that starts one row.
- done_o  output  1  one-cycle pulse when the row has been fully emitted.
- val_i  input  1  input pixel valid; no backpressure.
- dat_i  input  PXL_WD  input pixel.
- val_o  output  1  output beat valid.
- hdr_o  output  1  qualifies val_o: 1 = filter-type header beat.
- dat_o  output  PXL_WD  filtered pixel, or {24'd0, 5'd0, typ} on a header beat.

Behaviour:
- Reset (async, rstn=0):
  - Outputs: val_o=0, hdr_o=0, dat_o=0, done_o=0.
  - FSM goes to IDLE; x_cnt=0, row_cnt=0.
  - Line buffer contents are don't-care; row 0 never reads them.
  - Reset mid-row abandons the row with no done_o; the next start_i is treated as row 0.
- FSM states: IDLE, HEAD, ROW, DONE.
  - IDLE: on start_i, latch cfg_typ_i into typ_r, then go to HEAD. start_i in any other state is ignored.
  - HEAD (exactly 1 cycle): val_o=1, hdr_o=1, dat_o={29'd0, typ_r}; then go to ROW.
  - ROW: each cycle with val_i=1 accepts one pixel and increments x_cnt. When the pixel with x_cnt==cfg_w_i-1 is accepted, go to DONE. val_i in IDLE, HEAD or DONE is ignored (dropped).
  - DONE (1 cycle): done_o=1 in the same cycle as the last pixel's val_o. x_cnt clears to 0. row_cnt increments, wrapping to 0 when it reaches cfg_h_i-1. Then go to IDLE.
- Timing:
  - The earliest accepted pixel is at start+2; the header occupies the start+1 output cycle.
  - Output latency is one cycle: a pixel accepted in cycle t appears on val_o/dat_o at t+1 with hdr_o=0.
  - Gaps in val_i produce gaps in val_o; ordering is preserved.
- Predictors, per byte lane i (8 bits each):
  - a = left byte: the previous pixel in this row, or 0 when x=0.
  - b = up byte: lbuf[x] from the previous row, or 0 when row_cnt=0.
  - c = up-left byte: lbuf[x-1], or 0 when x=0 or row_cnt=0.
  - a and c come from registers that hold the last accepted pixel and the last read up value.
- Filter equations (all results mod 256):
  - None: out = cur.
  - Sub: out = cur - a.
  - Up: out = cur - b.
  - Average: out = cur - ((a+b) >> 1), with a 9-bit sum and no overflow loss.
  - Paeth: p = a+b-c in signed 10-bit; pa=|p-a|, pb=|p-b|, pc=|p-c|.
    - pred = a if pa<=pb and pa<=pc; else b if pb<=pc; else c.
    - out = cur - pred.
- Line buffer:
  - MAX_W x PXL_WD storage with read-before-write at index x.
  - The current pixel is written in the same cycle its up value is consumed, so lbuf always holds the previous row's raw (unfiltered) pixels.
- Width 1: the single pixel is both first and last; DONE follows immediately.

Test Plan:
- Reset then row 0, W=4, typ=1 (Sub), pixels 0x10203040, 0x11213141, 0x12223242, 0x20304050 -> header dat_o=0x1, then 0x10203040, 0x01010101, 0x01010101, 0x0E0E0E0E; done_o aligned with the last beat.
- Row 1, W=4, typ=2 (Up), all pixels 0x05050505 after row 0 = 0x01020304 x4 -> outputs 0x04030201 x4. Row 0 of a new frame with Up -> outputs equal inputs.
- Average with a=0xFF, b=0xFF, cur=0x00 -> lane output 0x01, confirming no 9-bit overflow loss. Paeth tie with a=b=c=0x40, cur=0x41 -> 0x01 (a chosen).
- val_i gaps: 3 pixels with 2 idle cycles between each -> val_o gaps mirror the input at 1-cycle latency. start_i pulsed mid-row -> ignored, no extra header.
- cfg_h_i=2, three rows -> row_cnt wraps, so the third row uses b=0: Up output equals the input.
- rstn asserted after 2 of 4 pixels, then a new start_i -> no done_o for the aborted row; the next row is treated as row 0, with outputs per the first scenario.

Source files
------------

// File: rtl/png_filter_row_if.sv
// png_filter_row_if: row start/done handshake plus the input and output pixel
// streams of png_filter_row.
//   start_i  row start pulse            done_o  row complete pulse
//   val_i    input pixel valid          dat_i   input pixel {R,G,B,A}
//   val_o    output beat valid          hdr_o   output beat is the type header
//   dat_o    filtered pixel or {29'd0, filter type}
// master = producer/consumer around the filter, slave = png_filter_row.
interface png_filter_row_if #(
  parameter int unsigned PXL_WD = 32
);
  logic              start_i;
  logic              done_o;
  logic              val_i;
  logic [PXL_WD-1:0] dat_i;
  logic              val_o;
  logic              hdr_o;
  logic [PXL_WD-1:0] dat_o;

  modport master (
    output start_i, val_i, dat_i,
    input  done_o, val_o, hdr_o, dat_o
  );

  modport slave (
    input  start_i, val_i, dat_i,
    output done_o, val_o, hdr_o, dat_o
  );
endinterface

// File: rtl/png_filter_row.sv
// png_filter_row: per-scanline PNG filter. For each row started by start_i it
// emits a one-beat filter-type header, then every accepted pixel filtered per
// byte lane (None/Sub/Up/Average/Paeth), and pulses done_o with the last beat.
// The raw previous row is kept in a line buffer for the Up/Average/Paeth
// predictors.
//   clk        rising-edge clock
//   rstn       asynchronous active-low reset
//   cfg_w_i    image width in pixels (1..MAX_W), stable during a frame
//   cfg_h_i    image height in rows (>=1), stable during a frame
//   cfg_typ_i  filter type, latched at row start (5..7 behave as None)
//   bus        slave side of png_filter_row_if (start/done, pixel in/out)
module png_filter_row #(
  parameter int unsigned MAX_W     = 512,
  parameter int unsigned PXL_WD    = 32,
  parameter int unsigned SIZE_W_WD = 16,
  parameter int unsigned SIZE_H_WD = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [SIZE_W_WD-1:0] cfg_w_i,
  input  logic [SIZE_H_WD-1:0] cfg_h_i,
  input  logic [2:0]           cfg_typ_i,
  png_filter_row_if.slave      bus
);
  localparam int unsigned LANES  = PXL_WD / 8;
  localparam int unsigned IDX_WD = (MAX_W > 1) ? $clog2(MAX_W) : 1;

  typedef enum logic [1:0] {IDLE, HEAD, ROW, DONE} state_t;

  state_t                state_q, state_d;
  logic [2:0]            typ_q;
  logic [SIZE_W_WD-1:0]  x_cnt_q, x_cnt_d;
  logic [SIZE_H_WD-1:0]  row_cnt_q, row_cnt_d;
  logic [PXL_WD-1:0]     left_q;     // last accepted raw pixel (a)
  logic [PXL_WD-1:0]     upl_q;      // last up value read (c for next pixel)
  logic                  pix_val_q;
  logic [PXL_WD-1:0]     pix_dat_q;
  logic [PXL_WD-1:0]     lbuf_q [MAX_W];

  logic                  accept, first_px, row0, last_px;
  logic [PXL_WD-1:0]     up_px, left_px, upl_px, filt_px;
  logic                  val_o_c, hdr_o_c, done_o_c;
  logic [PXL_WD-1:0]     dat_o_c;

  function automatic logic [7:0] filt(input logic [2:0] typ, input logic [7:0] cur,
                                      input logic [7:0] a, input logic [7:0] b,
                                      input logic [7:0] c);
    logic [8:0]        sum;
    logic signed [9:0] p, da, db, dc, pa, pb, pc;
    logic [7:0]        pred;
    sum = {1'b0, a} + {1'b0, b};
    p   = $signed({2'b00, a}) + $signed({2'b00, b}) - $signed({2'b00, c});
    da  = p - $signed({2'b00, a});
    db  = p - $signed({2'b00, b});
    dc  = p - $signed({2'b00, c});
    pa  = (da < 0) ? -da : da;
    pb  = (db < 0) ? -db : db;
    pc  = (dc < 0) ? -dc : dc;
    case (typ)
      3'd1:    pred = a;
      3'd2:    pred = b;
      3'd3:    pred = sum[8:1];
      3'd4:    pred = (pa <= pb && pa <= pc) ? a : ((pb <= pc) ? b : c);
      default: pred = '0;
    endcase
    return cur - pred;
  endfunction

  assign accept   = (state_q == ROW) && bus.val_i;
  assign first_px = (x_cnt_q == '0);
  assign row0     = (row_cnt_q == '0);
  assign last_px  = (x_cnt_q == cfg_w_i - SIZE_W_WD'(1));

  // Read-before-write: the up value is taken from the old row while the
  // current raw pixel overwrites the same slot on this edge.
  assign up_px   = row0 ? '0 : lbuf_q[x_cnt_q[IDX_WD-1:0]];
  assign left_px = first_px ? '0 : left_q;
  assign upl_px  = first_px ? '0 : upl_q;

  always_comb begin
    filt_px = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      filt_px[i*8 +: 8] = filt(typ_q, bus.dat_i[i*8 +: 8], left_px[i*8 +: 8],
                               up_px[i*8 +: 8], upl_px[i*8 +: 8]);
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start_i) state_d = HEAD;
      HEAD:    state_d = ROW;
      ROW:     if (accept && last_px) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    x_cnt_d   = x_cnt_q;
    row_cnt_d = row_cnt_q;
    if (accept) x_cnt_d = x_cnt_q + SIZE_W_WD'(1);
    if (state_q == DONE) begin
      x_cnt_d   = '0;
      row_cnt_d = (row_cnt_q >= cfg_h_i - SIZE_H_WD'(1)) ? '0 : row_cnt_q + SIZE_H_WD'(1);
    end
  end

  // Output logic: header is driven straight from HEAD; pixel beats come from
  // the one-cycle pipeline register.
  always_comb begin
    val_o_c  = pix_val_q;
    hdr_o_c  = 1'b0;
    dat_o_c  = pix_dat_q;
    done_o_c = (state_q == DONE);
    if (state_q == HEAD) begin
      val_o_c      = 1'b1;
      hdr_o_c      = 1'b1;
      dat_o_c      = '0;
      dat_o_c[2:0] = typ_q;
    end
  end

  assign bus.val_o  = val_o_c;
  assign bus.hdr_o  = hdr_o_c;
  assign bus.dat_o  = dat_o_c;
  assign bus.done_o = done_o_c;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      typ_q     <= '0;
      x_cnt_q   <= '0;
      row_cnt_q <= '0;
      left_q    <= '0;
      upl_q     <= '0;
      pix_val_q <= 1'b0;
      pix_dat_q <= '0;
    end else begin
      state_q   <= state_d;
      x_cnt_q   <= x_cnt_d;
      row_cnt_q <= row_cnt_d;
      pix_val_q <= accept;
      if (state_q == IDLE && bus.start_i) typ_q <= cfg_typ_i;
      if (accept) begin
        left_q    <= bus.dat_i;
        upl_q     <= up_px;
        pix_dat_q <= filt_px;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) lbuf_q[x_cnt_q[IDX_WD-1:0]] <= bus.dat_i;
  end
endmodule
